// File: rtl/fast_accel_mac_pipe.sv
// fast_accel_mac_pipe
// Pipelined multiply-accumulate unit for the fast_accel datapath. It sits
// between operand fetch and result writeback. Each element is either a plain
// product or part of a running accumulation closed by acc_last. Results are
// resized to OUT_W bits by saturation or truncation.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   ce         clock enable; 0 freezes every register and forces in_ready=0
//   in_valid   din0/din1/op_signed/acc_en/acc_last are valid
//   in_ready   block accepts input this cycle
//   din0       multiplicand (A_W bits)
//   din1       multiplier (B_W bits)
//   op_signed  1: operands are two's complement, 0: unsigned
//   acc_en     1: add the product into the running accumulator
//   acc_last   with acc_en: emit the accumulated sum, then clear it
//   out_valid  dout/dout_sat are valid
//   out_ready  consumer takes the result
//   dout       resized product or sum (OUT_W bits)
//   dout_sat   result did not fit OUT_W (clamped or truncated)
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both 1 on that side. Once out_valid is 1, out_valid and dout hold until the
// edge where out_ready=1 and ce=1. in_valid is sampled only when in_ready=1.
//
// Pipeline: single global stall. adv = ce & (~out_valid | out_ready), and
// every stage moves when adv is 1. S1 registers the operands. S2 multiplies.
// S3..S(NUM_STAGE-1) carry the product. S(NUM_STAGE) accumulates, resizes and
// drives the outputs. Bubbles travel as cleared valid bits.
// ACC_W must be larger than OUT_W.

module fast_accel_mac_pipe #(
  parameter int A_W       = 16,
  parameter int B_W       = 16,
  parameter int OUT_W     = 22,
  parameter int ACC_W     = 40,
  parameter int NUM_STAGE = 4,
  parameter bit SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   din0,
  input  logic [B_W-1:0]   din1,
  input  logic             op_signed,
  input  logic             acc_en,
  input  logic             acc_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] dout,
  output logic             dout_sat
);

  localparam int P_W = A_W + B_W;
  // Number of product-carrying stages: S2..S(NUM_STAGE-1)
  localparam int NP  = NUM_STAGE - 2;

  logic adv;

  // Stage 1: registered operands and control
  logic           s1_valid;
  logic [A_W-1:0] s1_a;
  logic [B_W-1:0] s1_b;
  logic           s1_sgn;
  logic           s1_en;
  logic           s1_last;

  // Stages 2..NUM_STAGE-1: product and control
  logic [NP-1:0]  p_valid;
  logic [NP-1:0]  p_sgn;
  logic [NP-1:0]  p_en;
  logic [NP-1:0]  p_last;
  logic [P_W-1:0] p_prod [NP];

  logic [ACC_W-1:0] acc;

  // Multiplier operands, extended to the full product width
  logic [P_W-1:0] a_ext;
  logic [P_W-1:0] b_ext;
  logic [P_W-1:0] mult;

  // Final-stage datapath
  logic             f_valid;
  logic             f_sgn;
  logic             f_en;
  logic             f_last;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] result;
  logic             emit;
  logic             ovf;
  logic [OUT_W-1:0] res_out;

  assign adv      = ce & (~out_valid | out_ready);
  assign in_ready = adv;

  // With both operands extended to P_W, the low P_W bits of the product are
  // correct for signed and unsigned operands alike.
  always_comb begin
    a_ext = P_W'(s1_a);
    b_ext = P_W'(s1_b);
    if (s1_sgn) begin
      a_ext = P_W'($signed(s1_a));
      b_ext = P_W'($signed(s1_b));
    end
    mult = a_ext * b_ext;
  end

  assign f_valid = p_valid[NP-1];
  assign f_sgn   = p_sgn[NP-1];
  assign f_en    = p_en[NP-1];
  assign f_last  = p_last[NP-1];

  always_comb begin
    prod_ext = ACC_W'(p_prod[NP-1]);
    if (f_sgn) prod_ext = ACC_W'($signed(p_prod[NP-1]));
    sum    = acc + prod_ext;
    result = f_en ? sum : prod_ext;
    // An element emits when it is a plain product or closes an accumulation
    emit   = f_valid & (~f_en | f_last);
  end

  // Resize: the range follows op_signed of the emitting element
  always_comb begin
    ovf     = 1'b0;
    res_out = result[OUT_W-1:0];
    if (f_sgn) begin
      // Fits when every bit from OUT_W-1 upward equals the sign bit
      ovf = ~((&result[ACC_W-1:OUT_W-1]) | ~(|result[ACC_W-1:OUT_W-1]));
      if (ovf && SATURATE) begin
        res_out = result[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                  : {1'b0, {(OUT_W-1){1'b1}}};
      end
    end else begin
      ovf = |result[ACC_W-1:OUT_W];
      if (ovf && SATURATE) res_out = {OUT_W{1'b1}};
    end
  end

  // Front stages
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sgn   <= 1'b0;
      s1_en    <= 1'b0;
      s1_last  <= 1'b0;
      p_valid  <= '0;
      p_sgn    <= '0;
      p_en     <= '0;
      p_last   <= '0;
      for (int i = 0; i < NP; i++) p_prod[i] <= '0;
    end else if (adv) begin
      // in_ready equals adv, so in_valid alone marks an accepted element
      s1_valid   <= in_valid;
      s1_a       <= din0;
      s1_b       <= din1;
      s1_sgn     <= op_signed;
      s1_en      <= acc_en;
      s1_last    <= acc_last;
      p_valid[0] <= s1_valid;
      p_sgn[0]   <= s1_sgn;
      p_en[0]    <= s1_en;
      p_last[0]  <= s1_last;
      p_prod[0]  <= mult;
      for (int i = 1; i < NP; i++) begin
        p_valid[i] <= p_valid[i-1];
        p_sgn[i]   <= p_sgn[i-1];
        p_en[i]    <= p_en[i-1];
        p_last[i]  <= p_last[i-1];
        p_prod[i]  <= p_prod[i-1];
      end
    end
  end

  // Final stage: accumulator and output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
      dout_sat  <= 1'b0;
    end else if (adv) begin
      out_valid <= emit;
      if (emit) begin
        dout     <= res_out;
        dout_sat <= ovf;
      end
      if (f_valid && f_en) acc <= f_last ? '0 : sum;
    end
  end

endmodule

// File: tb/tb_fast_accel_mac_pipe.sv
// Testbench for fast_accel_mac_pipe. It runs one truncating instance and one
// saturating instance side by side on the same inputs. The first part applies a
// table of directed single products. Hand-written sequences then cover
// accumulation, ce hold, random back-pressure and reset during an
// accumulation. A scoreboard queue holds the expected {trunc, sat, flag}
// triples in acceptance order.

module tb_fast_accel_mac_pipe;

  localparam int A_W       = 16;
  localparam int B_W       = 16;
  localparam int OUT_W     = 22;
  localparam int ACC_W     = 40;
  localparam int NUM_STAGE = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic             ce, in_valid, out_ready;
  logic [A_W-1:0]   din0;
  logic [B_W-1:0]   din1;
  logic             op_signed, acc_en, acc_last;
  logic             in_ready_t, in_ready_s;
  logic             out_valid_t, out_valid_s;
  logic [OUT_W-1:0] dout_t, dout_s;
  logic             sat_t, sat_s;

  fast_accel_mac_pipe #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W), .ACC_W(ACC_W),
                        .NUM_STAGE(NUM_STAGE), .SATURATE(1'b0)) u_trunc (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready_t),
    .din0(din0), .din1(din1), .op_signed(op_signed), .acc_en(acc_en),
    .acc_last(acc_last), .out_valid(out_valid_t), .out_ready(out_ready),
    .dout(dout_t), .dout_sat(sat_t)
  );

  fast_accel_mac_pipe #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W), .ACC_W(ACC_W),
                        .NUM_STAGE(NUM_STAGE), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready_s),
    .din0(din0), .din1(din1), .op_signed(op_signed), .acc_en(acc_en),
    .acc_last(acc_last), .out_valid(out_valid_s), .out_ready(out_ready),
    .dout(dout_s), .dout_sat(sat_s)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;
  int acc_cyc  = 0;
  logic chk_ready = 1'b0;
  logic [2*OUT_W:0] exp_q[$];  // {dout truncating, dout saturating, dout_sat}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_exp(input logic [OUT_W-1:0] t, input logic [OUT_W-1:0] s, input logic f);
    exp_q.push_back({t, s, f});
  endtask

  // Outputs are sampled on the falling edge. A result is consumed on the
  // next rising edge when out_valid, out_ready and ce are all 1.
  always @(negedge clk) begin
    logic [2*OUT_W:0] e;
    if (reset && ce && out_valid_t && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got dout 0x%0h, expected no result", dout_t);
      end else begin
        e = exp_q.pop_front();
        check("dout_trunc", 32'(dout_t), 32'(e[2*OUT_W:OUT_W+1]));
        check("dout_satmode", 32'(dout_s), 32'(e[OUT_W:1]));
        check("sat_flag_trunc", 32'(sat_t), 32'(e[0]));
        check("sat_flag_satmode", 32'(sat_s), 32'(e[0]));
        check("out_valid_satmode", 32'(out_valid_s), 32'd1);
      end
    end
    if (chk_ready) begin
      if (!ce || (out_valid_t && !out_ready)) check("in_ready_stall", 32'(in_ready_t), 32'd0);
      else                                    check("in_ready_go", 32'(in_ready_t), 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+2. Holds the element until it is accepted, and returns
  // at posedge+2 after the accepting edge with in_valid dropped.
  task automatic send(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                      input logic sg, input logic en, input logic last);
    bit got = 0;
    din0 = a; din1 = b; op_signed = sg; acc_en = en; acc_last = last;
    in_valid = 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (in_ready_t) begin
        got = 1;
        acc_cyc = cyc;  // the transfer cycle counts as cycle 0
      end
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    if (!got) begin
      n_checks++;
      $display("FAIL send_timeout: got no in_ready in 200 cycles, expected acceptance");
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
      @(posedge clk); #2;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (NUM_STAGE + 2) begin
      @(posedge clk); #2;
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [A_W-1:0]   a;
    logic [B_W-1:0]   b;
    logic             sg;
    logic [OUT_W-1:0] et;
    logic [OUT_W-1:0] es;
    logic             esat;
  } vec_t;

  vec_t tbl[12];
  bit   done;
  int   burst;
  int   n0;

  initial begin
    tbl[0]  = '{16'd1000,  16'd3000,  1'b0, 22'd3000000, 22'd3000000, 1'b0};
    tbl[1]  = '{16'hFFFF,  16'hFFFF,  1'b0, 22'h3E0001,  22'h3FFFFF,  1'b1};
    tbl[2]  = '{16'hFFFD,  16'd7,     1'b1, 22'h3FFFEB,  22'h3FFFEB,  1'b0};
    tbl[3]  = '{16'h8000,  16'h7FFF,  1'b1, 22'h008000,  22'h200000,  1'b1};
    tbl[4]  = '{16'd0,     16'd12345, 1'b0, 22'd0,       22'd0,       1'b0};
    tbl[5]  = '{16'hFFFF,  16'hFFFF,  1'b1, 22'd1,       22'd1,       1'b0};
    tbl[6]  = '{16'd2048,  16'd1024,  1'b1, 22'h200000,  22'h1FFFFF,  1'b1};
    tbl[7]  = '{16'd2048,  16'd1024,  1'b0, 22'h200000,  22'h200000,  1'b0};
    tbl[8]  = '{16'hF800,  16'd1024,  1'b1, 22'h200000,  22'h200000,  1'b0};
    tbl[9]  = '{16'd2048,  16'd2048,  1'b0, 22'd0,       22'h3FFFFF,  1'b1};
    tbl[10] = '{16'd2049,  16'd2047,  1'b0, 22'h3FFFFF,  22'h3FFFFF,  1'b0};
    tbl[11] = '{16'hFFFD,  16'd7,     1'b0, 22'h06FFEB,  22'h06FFEB,  1'b0};

    reset = 1'b0; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    din0 = '0; din1 = '0; op_signed = 1'b0; acc_en = 1'b0; acc_last = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("reset_out_valid", 32'(out_valid_t), 32'd0);
    check("reset_dout", 32'(dout_t), 32'd0);
    check("reset_dout_sat", 32'(sat_t), 32'd0);
    reset = 1'b1;
    @(posedge clk); #2;

    // Single products with latency measurement
    foreach (tbl[i]) begin
      bit seen = 0;
      int lat  = -1;
      push_exp(tbl[i].et, tbl[i].es, tbl[i].esat);
      send(tbl[i].a, tbl[i].b, tbl[i].sg, 1'b0, 1'b0);
      for (int k = 0; k < 50 && !seen; k++) begin
        @(negedge clk);
        if (out_valid_t) begin
          seen = 1;
          lat  = cyc - acc_cyc;
        end
      end
      check("latency", 32'(lat), 32'(NUM_STAGE));
      @(posedge clk); #2;
      wait_drain();
    end

    // Accumulation: 200+1200+3000+5600, exactly one result
    n0 = n_out;
    push_exp(22'd10000, 22'd10000, 1'b0);
    send(16'd10, 16'd20, 1'b0, 1'b1, 1'b0);
    send(16'd30, 16'd40, 1'b0, 1'b1, 1'b0);
    send(16'd50, 16'd60, 1'b0, 1'b1, 1'b0);
    send(16'd70, 16'd80, 1'b0, 1'b1, 1'b1);
    wait_drain();
    check("acc_single_output", 32'(n_out - n0), 32'd1);

    // Signed accumulation: -21 + 10 = -11
    push_exp(22'h3FFFF5, 22'h3FFFF5, 1'b0);
    send(16'hFFFD, 16'd7, 1'b1, 1'b1, 1'b0);
    send(16'd2,    16'd5, 1'b1, 1'b1, 1'b1);
    // Unsigned sum past OUT_W: 2*0xFFFE0001 = 0x1FFFC0002
    push_exp(22'h3C0002, 22'h3FFFFF, 1'b1);
    send(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b1);
    // A plain product mid-accumulation leaves the accumulator alone
    push_exp(22'd12, 22'd12, 1'b0);
    push_exp(22'd201, 22'd201, 1'b0);
    send(16'd10, 16'd20, 1'b0, 1'b1, 1'b0);
    send(16'd3,  16'd4,  1'b0, 1'b0, 1'b0);
    send(16'd1,  16'd1,  1'b0, 1'b1, 1'b1);
    wait_drain();

    // ce=0 holds a pending result and ignores out_ready
    out_ready = 1'b0;
    push_exp(22'd99, 22'd99, 1'b0);
    send(16'd9, 16'd11, 1'b0, 1'b0, 1'b0);
    repeat (NUM_STAGE + 1) begin
      @(posedge clk); #2;
    end
    ce = 1'b0; out_ready = 1'b1;
    n0 = n_out;
    repeat (3) begin
      @(negedge clk);
      check("ce_hold_out_valid", 32'(out_valid_t), 32'd1);
      check("ce_hold_dout", 32'(dout_t), 32'd99);
      check("ce_hold_in_ready", 32'(in_ready_t), 32'd0);
      @(posedge clk); #2;
    end
    ce = 1'b1;
    wait_drain();
    check("ce_release_single_output", 32'(n_out - n0), 32'd1);

    // Back-pressure and ce bursts: k*(k+1), k=1..8
    for (int k = 1; k <= 8; k++) push_exp(22'(k * (k + 1)), 22'(k * (k + 1)), 1'b0);
    chk_ready = 1'b1;
    done  = 0;
    burst = 0;
    fork
      begin
        for (int k = 1; k <= 8; k++) send(16'(k), 16'(k + 1), 1'b0, 1'b0, 1'b0);
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          if (burst > 0) begin
            ce = 1'b0;
            burst--;
          end else if ($urandom_range(0, 4) == 0) begin
            ce = 1'b0;
            burst = $urandom_range(0, 2);
          end else begin
            ce = 1'b1;
          end
          @(posedge clk); #2;
        end
      end
    join
    ce = 1'b1; out_ready = 1'b1;
    wait_drain();
    chk_ready = 1'b0;

    // Reset in the middle of an accumulation
    send(16'd5, 16'd5, 1'b0, 1'b1, 1'b0);
    send(16'd6, 16'd6, 1'b0, 1'b1, 1'b0);
    repeat (NUM_STAGE + 2) begin
      @(posedge clk); #2;
    end
    reset = 1'b0;
    #1;
    check("rst_async_out_valid", 32'(out_valid_t), 32'd0);
    check("rst_async_dout", 32'(dout_t), 32'd0);
    @(negedge clk);
    check("rst_hold_out_valid", 32'(out_valid_t), 32'd0);
    check("rst_hold_dout", 32'(dout_t), 32'd0);
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    push_exp(22'd6, 22'd6, 1'b0);
    send(16'd2, 16'd3, 1'b0, 1'b1, 1'b1);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
